// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: measures incoming Hsync/Vsync timing, qualifies it
// over consecutive frames, then recovers pixel coordinates and an active-video flag.
module vga_timing_monitor #(
   parameter int H_ACT_START = 144,
   parameter int H_ACT_LEN   = 640,
   parameter int V_ACT_START = 35,
   parameter int V_ACT_LEN   = 480
) (
   input  logic        mclk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        Hsync,
   input  logic        Vsync,
   output logic        locked,
   output logic [11:0] h_total,
   output logic [10:0] v_total,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        active,
   output logic        frame_start,
   output logic        timing_err
);

   localparam logic [11:0] H_MAX = 12'hFFF;
   localparam logic [10:0] V_MAX = 11'h7FF;
   localparam logic [11:0] H_LO  = 12'(H_ACT_START);
   localparam logic [11:0] H_HI  = 12'(H_ACT_START + H_ACT_LEN);
   localparam logic [10:0] V_LO  = 11'(V_ACT_START);
   localparam logic [10:0] V_HI  = 11'(V_ACT_START + V_ACT_LEN);

   typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

   state_t      state_q, state_d;
   logic        hsMeta_q, hsSync_q, vsMeta_q, vsSync_q;
   logic        hsHist_q, vsHist_q;
   logic [11:0] hCnt_q, hCnt_d;
   logic [10:0] vCnt_q, vCnt_d;
   logic        vsPend_q, vsPend_d;
   logic [11:0] refH_q, refH_d;
   logic        refValid_q, refValid_d;
   logic [11:0] hTotal_q, hTotal_d;
   logic [10:0] vTotal_q, vTotal_d;
   logic        locked_q, active_q, frameStart_q, timingErr_q;
   logic [9:0]  pixX_q, pixY_q;

   logic        hRise, vRise, lineEnd, frameEnd;
   logic [12:0] lineLen;
   logic [11:0] frameLen;
   logic        hSatTick, vSatTick, timeout;
   logic        lineMatchRef, lineMatchTot, frameMatch;
   logic        errPulse, activeD;

   // Two-flop synchronizers run every mclk; edge history only advances on pixel ticks.
   always_ff @(posedge mclk) begin
      if (rst) begin
         hsMeta_q <= 1'b0;
         hsSync_q <= 1'b0;
         vsMeta_q <= 1'b0;
         vsSync_q <= 1'b0;
         hsHist_q <= 1'b0;
         vsHist_q <= 1'b0;
      end else begin
         hsMeta_q <= Hsync;
         hsSync_q <= hsMeta_q;
         vsMeta_q <= Vsync;
         vsSync_q <= vsMeta_q;
         if (pix_en) begin
            hsHist_q <= hsSync_q;
            vsHist_q <= vsSync_q;
         end
      end
   end

   assign hRise    = pix_en && hsSync_q && !hsHist_q;
   assign vRise    = pix_en && vsSync_q && !vsHist_q;
   assign lineEnd  = hRise;
   assign frameEnd = lineEnd && (vsPend_q || vRise);
   assign lineLen  = {1'b0, hCnt_q} + 13'd1;
   assign frameLen = {1'b0, vCnt_q} + 12'd1;

   assign hSatTick = pix_en && !lineEnd && (hCnt_q == H_MAX - 12'd1);
   assign vSatTick = lineEnd && !frameEnd && (vCnt_q == V_MAX - 11'd1);
   assign timeout  = hSatTick || vSatTick;

   assign lineMatchRef = (lineLen == {1'b0, refH_q});
   assign lineMatchTot = (lineLen == {1'b0, hTotal_q});
   assign frameMatch   = (frameLen == {1'b0, vTotal_q});

   always_comb begin
      hCnt_d   = hCnt_q;
      vCnt_d   = vCnt_q;
      vsPend_d = vsPend_q;
      if (pix_en) begin
         if (lineEnd) begin
            hCnt_d = '0;
         end else if (hCnt_q != H_MAX) begin
            hCnt_d = hCnt_q + 12'd1;
         end
         if (frameEnd) begin
            vCnt_d   = '0;
            vsPend_d = 1'b0;
         end else begin
            if (lineEnd && (vCnt_q != V_MAX)) begin
               vCnt_d = vCnt_q + 11'd1;
            end
            if (vRise) begin
               vsPend_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         hCnt_q   <= '0;
         vCnt_q   <= '0;
         vsPend_q <= 1'b0;
      end else begin
         hCnt_q   <= hCnt_d;
         vCnt_q   <= vCnt_d;
         vsPend_q <= vsPend_d;
      end
   end

   // Saturation overrides everything; otherwise the FSM only reacts at line boundaries.
   always_comb begin
      state_d    = state_q;
      refH_d     = refH_q;
      refValid_d = refValid_q;
      hTotal_d   = hTotal_q;
      vTotal_d   = vTotal_q;
      errPulse   = 1'b0;
      if (timeout) begin
         errPulse = (state_q == LOCKED);
         state_d  = SEARCH;
      end else if (lineEnd) begin
         case (state_q)
            SEARCH: begin
               if (frameEnd) begin
                  state_d    = MEASURE;
                  refValid_d = 1'b0;
               end
            end
            MEASURE: begin
               if (refValid_q && !lineMatchRef) begin
                  state_d = SEARCH;
               end else begin
                  if (!refValid_q) begin
                     refH_d     = lineLen[11:0];
                     refValid_d = 1'b1;
                  end
                  if (frameEnd) begin
                     hTotal_d = refValid_q ? refH_q : lineLen[11:0];
                     vTotal_d = frameLen[10:0];
                     state_d  = VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (!lineMatchTot || (frameEnd && !frameMatch)) begin
                  state_d = SEARCH;
               end else if (frameEnd) begin
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (!lineMatchTot || (frameEnd && !frameMatch)) begin
                  errPulse = 1'b1;
                  state_d  = SEARCH;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q    <= SEARCH;
         refH_q     <= '0;
         refValid_q <= 1'b0;
         hTotal_q   <= '0;
         vTotal_q   <= '0;
      end else begin
         state_q    <= state_d;
         refH_q     <= refH_d;
         refValid_q <= refValid_d;
         hTotal_q   <= hTotal_d;
         vTotal_q   <= vTotal_d;
      end
   end

   assign activeD = (state_d == LOCKED) &&
                    (hCnt_d >= H_LO) && (hCnt_d < H_HI) &&
                    (vCnt_d >= V_LO) && (vCnt_d < V_HI);

   // Coordinates are taken from the post-tick counters so they line up with the pixel
   // being presented on that tick.
   always_ff @(posedge mclk) begin
      if (rst) begin
         locked_q     <= 1'b0;
         active_q     <= 1'b0;
         frameStart_q <= 1'b0;
         timingErr_q  <= 1'b0;
         pixX_q       <= '0;
         pixY_q       <= '0;
      end else begin
         locked_q     <= (state_d == LOCKED);
         frameStart_q <= frameEnd;
         timingErr_q  <= errPulse;
         if (pix_en) begin
            active_q <= activeD;
            pixX_q   <= activeD ? 10'(hCnt_d - H_LO) : '0;
            pixY_q   <= activeD ? 10'(vCnt_d - V_LO) : '0;
         end
      end
   end

   assign locked      = locked_q;
   assign h_total     = hTotal_q;
   assign v_total     = vTotal_q;
   assign pix_x       = pixX_q;
   assign pix_y       = pixY_q;
   assign active      = active_q;
   assign frame_start = frameStart_q;
   assign timing_err  = timingErr_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized-pacing bench for vga_timing_monitor: a tick-level reference model fills
// scoreboard queues that a negedge monitor drains as the DUT presents its outputs.
module tb_vga_timing_monitor;

   localparam int HS    = 6;
   localparam int HL    = 20;
   localparam int VS    = 2;
   localparam int VL    = 6;
   localparam int LINE  = 36;
   localparam int LINES = 10;
   localparam int HSW   = 4;

   logic        mclk   = 1'b0;
   logic        rst    = 1'b1;
   logic        pix_en = 1'b0;
   logic        Hsync  = 1'b0;
   logic        Vsync  = 1'b0;
   logic        locked;
   logic [11:0] h_total;
   logic [10:0] v_total;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        active;
   logic        frame_start;
   logic        timing_err;

   vga_timing_monitor #(
      .H_ACT_START(HS),
      .H_ACT_LEN  (HL),
      .V_ACT_START(VS),
      .V_ACT_LEN  (VL)
   ) dut (
      .mclk       (mclk),
      .rst        (rst),
      .pix_en     (pix_en),
      .Hsync      (Hsync),
      .Vsync      (Vsync),
      .locked     (locked),
      .h_total    (h_total),
      .v_total    (v_total),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .active     (active),
      .frame_start(frame_start),
      .timing_err (timing_err)
   );

   always #5 mclk = ~mclk;

   typedef struct {
      bit act;
      int px;
      int py;
      bit fs;
      bit err;
      bit lk;
   } tickExp_t;

   typedef struct {
      bit lk;
      int ht;
      int vt;
   } frameExp_t;

   tickExp_t  pixQ[$];
   frameExp_t fsQ[$];
   int        errQ[$];

   int checks    = 0;
   int errors    = 0;
   int errPulses = 0;
   int tickNum   = 0;
   int vOff      = 0;

   // Reference model: tick/line counts and the number of consecutive qualified frames.
   int mH = 0, mV = 0, qual = 0, refLen = -1, hTot = 0, vTot = 0;
   bit mHistH = 0, mHistV = 0, mPend = 0, pinPrevH = 0, pinPrevV = 0;

   logic tickAtEdge = 1'b0;
   always @(posedge mclk) tickAtEdge <= pix_en && !rst;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mH = 0; mV = 0; qual = 0; refLen = -1; hTot = 0; vTot = 0;
      mHistH = 0; mHistV = 0; mPend = 0;
   endtask

   task automatic modelTick(input bit h, input bit v);
      bit seenH, seenV, hr, vr, lineB, frameB, tmo, brk;
      int lineLen, frameLen;
      tickExp_t te;
      frameExp_t fe;
      seenH = pinPrevH;
      seenV = pinPrevV;
      pinPrevH = h;
      pinPrevV = v;
      hr = seenH && !mHistH;
      vr = seenV && !mHistV;
      mHistH = seenH;
      mHistV = seenV;
      lineB  = hr;
      frameB = hr && (mPend || vr);
      lineLen  = mH + 1;
      frameLen = mV + 1;
      tmo = 0;
      brk = 0;
      if (lineB) mH = 0;
      else if (mH < 4095) begin
         mH++;
         if (mH == 4095) tmo = 1;
      end
      if (frameB) begin
         mV = 0;
         mPend = 0;
      end else begin
         if (lineB && mV < 2047) begin
            mV++;
            if (mV == 2047) tmo = 1;
         end
         if (vr) mPend = 1;
      end
      te.err = 0;
      if (tmo) brk = 1;
      else if (lineB) begin
         case (qual)
            0: if (frameB) begin qual = 1; refLen = -1; end
            1: begin
               if (refLen < 0) refLen = lineLen;
               else if (lineLen != refLen) brk = 1;
               if (!brk && frameB) begin
                  hTot = refLen;
                  vTot = frameLen;
                  qual = 2;
               end
            end
            default: begin
               if (lineLen != hTot || (frameB && frameLen != vTot)) brk = 1;
               else if (frameB) qual = 3;
            end
         endcase
      end
      if (brk) begin
         te.err = (qual == 3);
         qual = 0;
      end
      te.lk  = (qual == 3);
      te.act = te.lk && (mH >= HS) && (mH < HS + HL) && (mV >= VS) && (mV < VS + VL);
      te.px  = te.act ? mH - HS : 0;
      te.py  = te.act ? mV - VS : 0;
      te.fs  = frameB;
      pixQ.push_back(te);
      if (frameB) begin
         fe.lk = te.lk;
         fe.ht = hTot;
         fe.vt = vTot;
         fsQ.push_back(fe);
      end
      if (te.err) errQ.push_back(tickNum);
      tickNum++;
   endtask

   // Scoreboard monitor: one pop per pixel tick, plus pops on each reported pulse.
   always @(negedge mclk) begin : monitorBlk
      tickExp_t te;
      frameExp_t fe;
      int ev;
      if (tickAtEdge) begin
         checkOutput("pix_queue_depth", pixQ.size(), 1);
         if (pixQ.size() > 0) begin
            te = pixQ.pop_front();
            checkOutput("active", active, te.act);
            checkOutput("pix_x", pix_x, te.px);
            checkOutput("pix_y", pix_y, te.py);
            checkOutput("frame_start", frame_start, te.fs);
            checkOutput("timing_err", timing_err, te.err);
            checkOutput("locked", locked, te.lk);
         end
      end else if (!rst) begin
         checkOutput("frame_start_idle", frame_start, 0);
         checkOutput("timing_err_idle", timing_err, 0);
      end
      if (frame_start === 1'b1) begin
         checkOutput("fs_queue_depth", fsQ.size(), 1);
         if (fsQ.size() > 0) begin
            fe = fsQ.pop_front();
            checkOutput("fs_locked", locked, fe.lk);
            checkOutput("fs_h_total", h_total, fe.ht);
            checkOutput("fs_v_total", v_total, fe.vt);
         end
      end
      if (timing_err === 1'b1) begin
         errPulses++;
         checkOutput("err_queue_depth", errQ.size(), 1);
         if (errQ.size() > 0) begin
            ev = errQ.pop_front();
            checkOutput("err_locked_low", locked, 0);
         end
      end
   end

   task automatic applyStimulus(input bit h, input bit v);
      int gap;
      gap = $urandom_range(2, 4);
      @(negedge mclk);
      pix_en = 1'b1;
      Hsync  = h;
      Vsync  = v;
      modelTick(h, v);
      @(negedge mclk);
      pix_en = 1'b0;
      repeat (gap - 1) @(negedge mclk);
   endtask

   task automatic doReset(input int cycles);
      @(negedge mclk);
      rst = 1'b1;
      repeat (cycles) @(negedge mclk);
      checkOutput("rst_locked", locked, 0);
      checkOutput("rst_active", active, 0);
      checkOutput("rst_frame_start", frame_start, 0);
      checkOutput("rst_timing_err", timing_err, 0);
      checkOutput("rst_h_total", h_total, 0);
      checkOutput("rst_v_total", v_total, 0);
      checkOutput("rst_pix_x", pix_x, 0);
      checkOutput("rst_pix_y", pix_y, 0);
      checkOutput("rst_pix_queue_left", pixQ.size(), 0);
      checkOutput("rst_fs_queue_left", fsQ.size(), 0);
      checkOutput("rst_err_queue_left", errQ.size(), 0);
      rst = 1'b0;
      modelReset();
      repeat (3) @(negedge mclk);
   endtask

   task automatic sendLines(input int off, input int first, input int last, input int shortLine);
      for (int l = first; l <= last; l++) begin
         int len;
         len = (l == shortLine) ? LINE - 1 : LINE;
         for (int t = 0; t < len; t++) begin
            int p;
            p = l * LINE + t;
            applyStimulus(t < HSW, (p >= off) && (p < off + 2 * LINE));
         end
      end
   endtask

   task automatic sendFrames(input int off, input int n);
      for (int f = 0; f < n; f++) sendLines(off, 0, LINES - 1, -1);
   endtask

   initial begin
      doReset(3);

      // Coincident Hsync/Vsync rises at every frame start
      sendFrames(0, 5);
      checkOutput("lock_locked", locked, 1);
      checkOutput("lock_h_total", h_total, LINE);
      checkOutput("lock_v_total", v_total, LINES);

      // Reset in the middle of a locked frame, then requalify
      sendLines(0, 0, 4, -1);
      doReset(2);
      sendLines(0, 5, LINES - 1, -1);
      sendFrames(0, 4);
      checkOutput("relock_after_reset", locked, 1);

      // Vsync rising part-way through a line defers the frame boundary
      vOff = $urandom_range(1, 2 * LINE);
      sendFrames(vOff, 5);
      checkOutput("voff_locked", locked, 1);
      checkOutput("voff_h_total", h_total, LINE);
      checkOutput("voff_v_total", v_total, LINES);

      // One short line while locked
      errPulses = 0;
      sendLines(vOff, 0, LINES - 1, 4);
      sendFrames(vOff, 4);
      checkOutput("short_line_err_pulses", errPulses, 1);
      checkOutput("short_line_relocked", locked, 1);

      // Sync loss: Hsync held low until the line counter saturates
      errPulses = 0;
      for (int i = 0; i < 4100; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("sync_loss_err_pulses", errPulses, 1);
      checkOutput("sync_loss_locked", locked, 0);

      repeat (4) @(negedge mclk);
      checkOutput("end_pix_queue_left", pixQ.size(), 0);
      checkOutput("end_fs_queue_left", fsQ.size(), 0);
      checkOutput("end_err_queue_left", errQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Receive-side counterpart of the VGA timing generator. The block samples an incoming Hsync/Vsync pair on pixel-clock-enable ticks and measures line length and frame height. It qualifies the timing over consecutive frames before asserting lock, then recovers per-pixel coordinates and an active-video flag for downstream capture logic. Once locked, any timing deviation or loss of sync is reported as an error.

## Interface
- H_ACT_START, 144, first active pixel index within the line (h_cnt units)
- H_ACT_LEN, 640, active pixels per line
- V_ACT_START, 35, first active line index within the frame (v_cnt units)
- V_ACT_LEN, 480, active lines per frame
- mclk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick strobe, one mclk wide; at most one tick per 3 mclk
- Hsync  in  1  incoming horizontal sync, active-high, asynchronous
- Vsync  in  1  incoming vertical sync, active-high, asynchronous
- locked  out  1  timing qualified
- h_total  out  12  measured pixel ticks per line
- v_total  out  11  measured lines per frame
- pix_x  out  10  h_cnt − H_ACT_START while active, else 0
- pix_y  out  10  v_cnt − V_ACT_START while active, else 0
- active  out  1  locked and inside the active window
- frame_start  out  1  one-mclk pulse at each frame boundary
- timing_err  out  1  one-mclk pulse when lock is lost

## Operation
- Hsync and Vsync each pass a 2-flop synchronizer clocked every mclk. The edge detector compares the synchronized level against its value at the previous pix_en tick.
- Line boundary: a pix_en tick on which Hsync shows a rising edge. The line length is h_cnt + 1, using the pre-reset value. h_cnt then loads 0. On all other ticks h_cnt increments.
- Vsync rising edge sets vs_pending.
- Frame boundary: a line boundary with vs_pending set, or with a Vsync rising edge on the same tick. At a frame boundary:
  - frame length is v_cnt + 1
  - v_cnt loads 0
  - vs_pending clears
  - frame_start pulses
- On a line boundary that is not a frame boundary, v_cnt increments.
- FSM states are SEARCH, MEASURE, VERIFY and LOCKED. Reset state is SEARCH.
  - SEARCH → MEASURE at a frame boundary. The first line length of the frame is latched into ref_h.
  - MEASURE: every line length must equal ref_h, otherwise → SEARCH. At the next frame boundary, ref_h is copied to h_total, the frame length to v_total, and the FSM moves → VERIFY.
  - VERIFY: every line must equal h_total and the frame must equal v_total. On match at the frame boundary → LOCKED. On mismatch → SEARCH.
  - LOCKED: a line or frame mismatch pulses timing_err, clears locked, and moves → SEARCH.
- Timeout: h_cnt saturates at 4095, or v_cnt saturates at 2047. On either, the FSM moves → SEARCH from any state, and timing_err pulses if it was LOCKED.
- active = locked and H_ACT_START ≤ h_cnt < H_ACT_START+H_ACT_LEN and V_ACT_START ≤ v_cnt < V_ACT_START+V_ACT_LEN.
- pix_x, pix_y and active are registered and update only on pix_en ticks.

## Timing
- Reset values:
  - locked, active, frame_start, timing_err = 0
  - h_total, v_total, pix_x, pix_y = 0
  - h_cnt, v_cnt, vs_pending, ref_h, edge history = 0
  - FSM = SEARCH
- Reset takes effect on the next mclk edge regardless of pix_en, including mid-frame or while LOCKED.
- Synchronizer latency: a pin change sampled at mclk edge N is visible to edge detection at edge N+2. h_cnt resets on the first pix_en tick at or after N+2.
- locked rises on the same mclk edge as the frame_start that closes VERIFY. This is the third frame boundary after a clean stream starts.
- timing_err and the fall of locked occur on the same edge as the offending boundary tick or the saturation tick.
- active, pix_x and pix_y reflect the counter values after the tick's update, registered on the same edge.
- Without pix_en, all counters and outputs hold, except that the frame_start and timing_err pulses deassert after one mclk.

## Test plan
- Reset: drive rst for 2 mclk mid-stream. All outputs are 0 and the FSM is SEARCH on the following edge.
- Lock: feed an 800×525 stream (Hsync high for ticks 0–95, pix_en every 4 mclk). locked = 1 at the 3rd frame_start, with h_total = 800 and v_total = 525.
- Coordinates: once locked, h_cnt=144/v_cnt=35 gives active=1, pix_x=0, pix_y=0. h_cnt=783/v_cnt=514 gives pix_x=639, pix_y=479. h_cnt=784 gives active=0, pix_x=0.
- Line error: while locked, shorten one line to 799 ticks. There is exactly one timing_err pulse, locked=0, and lock is regained three frame boundaries later.
- Sync loss: while locked, hold Hsync low. timing_err pulses when h_cnt reaches 4095, and locked=0.
- Coincident edges: Vsync and Hsync rise on the same tick. That tick is a frame boundary, v_cnt=0 and frame_start pulses once.
